// File: rtl/micro_sequencer_pkg.sv
// Shared definitions for the micro-sequencer.
// Holds the branch-condition codes carried in each microword and the
// bit positions of the JUMP_ADDR and COND fields.
package micro_sequencer_pkg;

  // Branch-condition codes (COND field of the microword)
  localparam logic [2:0] COND_NEXT   = 3'd0;
  localparam logic [2:0] COND_N      = 3'd1;
  localparam logic [2:0] COND_Z      = 3'd2;
  localparam logic [2:0] COND_V      = 3'd3;
  localparam logic [2:0] COND_C      = 3'd4;
  localparam logic [2:0] COND_IR13   = 3'd5;
  localparam logic [2:0] COND_ALWAYS = 3'd6;
  localparam logic [2:0] COND_DECODE = 3'd7;

  // JUMP_ADDR occupies the low address-width bits of the microword
  localparam int JUMP_LSB = 0;

  // COND sits directly above JUMP_ADDR, so its LSB is the address width
  function automatic int cond_lsb(input int addr_w);
    return JUMP_LSB + addr_w;
  endfunction

endpackage

// File: rtl/micro_sequencer_store.sv
// micro_store: control-store array for the micro-sequencer.
// One synchronous write port and one combinational read port. A write to
// the address being read in the same cycle is forwarded to the read data
// (write-first), so the fetch that lands at that edge sees the new word.
// Contents are never reset.
//   CLK      clock
//   i_we     write enable
//   i_waddr  write address
//   i_wdata  write data
//   i_raddr  read address
//   o_rdata  read data (combinational)
module micro_store
  import micro_sequencer_pkg::*;
#(
  parameter int ADDR_W = 11,
  parameter int WORD_W = 41
) (
  input  logic              CLK,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WORD_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [WORD_W-1:0] o_rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [WORD_W-1:0] r_mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = (i_we && (i_waddr == i_raddr)) ? i_wdata : r_mem[i_raddr];

endmodule

// File: rtl/micro_sequencer.sv
// micro_sequencer: microprogram sequencer with a writable control store.
// Each unstalled cycle it selects the next control-store address from the
// current microword's COND/JUMP_ADDR fields, the condition flags and the
// IR dispatch address, then registers that address (CSA) and its microword
// (MIR_WORD) together.
//   CLK, RESET_InHigh        clock, synchronous active-high reset
//   STALL_InHigh             hold CSA / MIR_WORD / MIR_VALID
//   DECODE_ADDRESS           dispatch target for COND_DECODE
//   FLAG_N/Z/V/C, IR13       branch-condition sources
//   CS_WE/CS_WADDR/CS_WDATA  control-store write port
//   MIR_WORD, CSA, MIR_VALID current microword, its address, valid flag
module micro_sequencer
  import micro_sequencer_pkg::*;
#(
  parameter int DATAWIDTH_BUS_ADDRESS = 11,
  parameter int DATAWIDTH_BUS_WORD    = 41,
  parameter int DATAWIDTH_COND        = 3
) (
  input  logic                             CLK,
  input  logic                             RESET_InHigh,
  input  logic                             STALL_InHigh,
  input  logic [DATAWIDTH_BUS_ADDRESS-1:0] DECODE_ADDRESS,
  input  logic                             FLAG_N,
  input  logic                             FLAG_Z,
  input  logic                             FLAG_V,
  input  logic                             FLAG_C,
  input  logic                             IR13,
  input  logic                             CS_WE,
  input  logic [DATAWIDTH_BUS_ADDRESS-1:0] CS_WADDR,
  input  logic [DATAWIDTH_BUS_WORD-1:0]    CS_WDATA,
  output logic [DATAWIDTH_BUS_WORD-1:0]    MIR_WORD,
  output logic [DATAWIDTH_BUS_ADDRESS-1:0] CSA,
  output logic                             MIR_VALID
);

  localparam int AW       = DATAWIDTH_BUS_ADDRESS;
  localparam int CW       = DATAWIDTH_COND;
  localparam int COND_LSB = cond_lsb(AW);

  logic [DATAWIDTH_BUS_WORD-1:0] r_mir;
  logic [AW-1:0]                 r_csa;
  logic                          r_valid;

  logic [AW-1:0]                 w_jump;
  logic [CW-1:0]                 w_cond;
  logic                          w_taken;
  logic [AW-1:0]                 w_next;
  logic [DATAWIDTH_BUS_WORD-1:0] w_fetch;

  assign w_jump = r_mir[JUMP_LSB +: AW];
  assign w_cond = r_mir[COND_LSB +: CW];

  // Condition select: does the current microword's branch condition hold?
  always_comb begin
    w_taken = 1'b0;
    case (w_cond)
      CW'(COND_N):      w_taken = FLAG_N;
      CW'(COND_Z):      w_taken = FLAG_Z;
      CW'(COND_V):      w_taken = FLAG_V;
      CW'(COND_C):      w_taken = FLAG_C;
      CW'(COND_IR13):   w_taken = IR13;
      CW'(COND_ALWAYS): w_taken = 1'b1;
      default:          w_taken = 1'b0;
    endcase
  end

  // Next-address mux. Until the first fetch has landed MIR_WORD holds the
  // reset value rather than a real microword, so sequencing restarts at 0.
  always_comb begin
    w_next = r_csa + AW'(1);
    if (!r_valid)                         w_next = '0;
    else if (w_cond == CW'(COND_DECODE))  w_next = DECODE_ADDRESS;
    else if (w_taken)                     w_next = w_jump;
  end

  micro_store #(
    .ADDR_W (AW),
    .WORD_W (DATAWIDTH_BUS_WORD)
  ) u_store (
    .CLK     (CLK),
    .i_we    (CS_WE),
    .i_waddr (CS_WADDR),
    .i_wdata (CS_WDATA),
    .i_raddr (w_next),
    .o_rdata (w_fetch)
  );

  // Fetch stage boundary: address and microword register together
  always_ff @(posedge CLK) begin
    if (RESET_InHigh) begin
      r_csa   <= '0;
      r_mir   <= '0;
      r_valid <= 1'b0;
    end else if (!STALL_InHigh) begin
      r_csa   <= w_next;
      r_mir   <= w_fetch;
      r_valid <= 1'b1;
    end
  end

  assign MIR_WORD  = r_mir;
  assign CSA       = r_csa;
  assign MIR_VALID = r_valid;

endmodule

// File: tb/tb_micro_sequencer.sv
module tb_micro_sequencer;

  logic        CLK = 1'b0;
  logic        RESET_InHigh;
  logic        STALL_InHigh;
  logic [10:0] DECODE_ADDRESS;
  logic        FLAG_N, FLAG_Z, FLAG_V, FLAG_C, IR13;
  logic        CS_WE;
  logic [10:0] CS_WADDR;
  logic [40:0] CS_WDATA;
  logic [40:0] MIR_WORD;
  logic [10:0] CSA;
  logic        MIR_VALID;

  micro_sequencer dut (
    .CLK            (CLK),
    .RESET_InHigh   (RESET_InHigh),
    .STALL_InHigh   (STALL_InHigh),
    .DECODE_ADDRESS (DECODE_ADDRESS),
    .FLAG_N         (FLAG_N),
    .FLAG_Z         (FLAG_Z),
    .FLAG_V         (FLAG_V),
    .FLAG_C         (FLAG_C),
    .IR13           (IR13),
    .CS_WE          (CS_WE),
    .CS_WADDR       (CS_WADDR),
    .CS_WDATA       (CS_WDATA),
    .MIR_WORD       (MIR_WORD),
    .CSA            (CSA),
    .MIR_VALID      (MIR_VALID)
  );

  always #5 CLK = ~CLK;

  // Behavioural reference: a plain array plus the architectural state
  logic [40:0] m_mem [2048];
  logic [10:0] m_csa;
  logic [40:0] m_word;
  logic        m_valid;

  int total  = 0;
  int passed = 0;

  function automatic logic [40:0] rnd_word();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[40:0];
  endfunction

  function automatic logic [40:0] mkword(input logic [2:0] cond, input logic [10:0] jump);
    logic [40:0] w;
    w = rnd_word();
    w[13:11] = cond;
    w[10:0]  = jump;
    return w;
  endfunction

  // Next address from the sequencing rules
  function automatic logic [10:0] model_next();
    logic [2:0]  cond;
    logic [4:0]  flags;
    if (!m_valid) return 11'd0;
    cond  = m_word[13:11];
    flags = {IR13, FLAG_C, FLAG_V, FLAG_Z, FLAG_N};
    if (cond == 3'd7) return DECODE_ADDRESS;
    if (cond == 3'd6) return m_word[10:0];
    if (cond == 3'd0) return m_csa + 11'd1;
    return flags[cond - 3'd1] ? m_word[10:0] : m_csa + 11'd1;
  endfunction

  task automatic tick();
    logic [10:0] nxt;
    logic [40:0] fw;
    @(posedge CLK);
    nxt = model_next();
    fw  = (CS_WE && CS_WADDR == nxt) ? CS_WDATA : m_mem[nxt];
    if (RESET_InHigh) begin
      m_csa = '0; m_word = '0; m_valid = 1'b0;
    end else if (!STALL_InHigh) begin
      m_csa = nxt; m_word = fw; m_valid = 1'b1;
    end
    if (CS_WE) m_mem[CS_WADDR] = CS_WDATA;
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cmp_state(input string tag);
    check({tag, "_csa"},   64'(CSA),       64'(m_csa));
    check({tag, "_mir"},   64'(MIR_WORD),  64'(m_word));
    check({tag, "_valid"}, 64'(MIR_VALID), 64'(m_valid));
  endtask

  task automatic wr(input logic [10:0] a, input logic [40:0] d);
    CS_WE = 1'b1; CS_WADDR = a; CS_WDATA = d;
    tick();
    CS_WE = 1'b0;
  endtask

  task automatic set_flags(input logic [4:0] f);
    {IR13, FLAG_C, FLAG_V, FLAG_Z, FLAG_N} = f;
  endtask

  logic [40:0] w0, w8, w1600;

  initial begin
    RESET_InHigh = 1'b1; STALL_InHigh = 1'b0; DECODE_ADDRESS = '0;
    set_flags(5'b0);
    CS_WE = 1'b0; CS_WADDR = '0; CS_WDATA = '0;
    m_csa = '0; m_word = '0; m_valid = 1'b0;
    repeat (2) tick();

    // Fill the whole store so no address is ever read unwritten
    for (int a = 0; a < 2048; a++) wr(11'(a), rnd_word());

    check("reset_csa",   64'(CSA),       64'd0);
    check("reset_mir",   64'(MIR_WORD),  64'd0);
    check("reset_valid", 64'(MIR_VALID), 64'd0);

    // Sequential then unconditional jump: 0, 1, 20
    w0 = mkword(3'd0, 11'(rnd_word()));
    wr(11'd0, w0);
    wr(11'd1, mkword(3'd6, 11'd20));
    RESET_InHigh = 1'b0;
    tick();
    check("seq_first_csa",   64'(CSA),       64'd0);
    check("seq_first_valid", 64'(MIR_VALID), 64'd1);
    check("seq_first_mir",   64'(MIR_WORD),  64'(w0));
    tick();
    check("seq_second_csa", 64'(CSA), 64'd1);
    tick();
    check("seq_jump_csa", 64'(CSA), 64'd20);
    cmp_state("seq_jump");

    // Conditional on Z, taken
    RESET_InHigh = 1'b1;
    wr(11'd0, mkword(3'd6, 11'd5));
    wr(11'd5, mkword(3'd2, 11'd40));
    RESET_InHigh = 1'b0;
    tick(); tick();
    check("z_at5_csa", 64'(CSA), 64'd5);
    set_flags(5'b00010);
    tick();
    check("z_taken_csa", 64'(CSA), 64'd40);
    cmp_state("z_taken");

    // Reset at CSA=40, also overriding a stall
    RESET_InHigh = 1'b1; STALL_InHigh = 1'b1;
    tick();
    STALL_InHigh = 1'b0;
    check("rst_mid_csa",   64'(CSA),       64'd0);
    check("rst_mid_mir",   64'(MIR_WORD),  64'd0);
    check("rst_mid_valid", 64'(MIR_VALID), 64'd0);

    // Conditional on Z, not taken while every other flag is set
    RESET_InHigh = 1'b0;
    set_flags(5'b11101);
    tick(); tick();
    tick();
    check("z_fall_csa", 64'(CSA), 64'd6);
    cmp_state("z_fall");

    // Dispatch from IR decode
    RESET_InHigh = 1'b1;
    set_flags(5'b0);
    w1600 = rnd_word();
    wr(11'd0, mkword(3'd0, 11'd0));
    wr(11'd1, mkword(3'd7, 11'd3));
    wr(11'd1600, w1600);
    DECODE_ADDRESS = 11'd1600;
    RESET_InHigh = 1'b0;
    tick(); tick();
    tick();
    check("decode_csa", 64'(CSA),      64'd1600);
    check("decode_mir", 64'(MIR_WORD), 64'(w1600));

    // Stall for three cycles at CSA=8, then advance with a colliding write
    RESET_InHigh = 1'b1;
    w8 = mkword(3'd0, 11'd100);
    wr(11'd0, mkword(3'd6, 11'd8));
    wr(11'd8, w8);
    wr(11'd9, rnd_word());
    RESET_InHigh = 1'b0;
    tick(); tick();
    check("stall_pre_csa", 64'(CSA), 64'd8);
    STALL_InHigh = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_flags(5'($urandom()));
      tick();
      check("stall_hold_csa",   64'(CSA),       64'd8);
      check("stall_hold_mir",   64'(MIR_WORD),  64'(w8));
      check("stall_hold_valid", 64'(MIR_VALID), 64'd1);
    end
    STALL_InHigh = 1'b0;
    CS_WE = 1'b1; CS_WADDR = 11'd9; CS_WDATA = 41'h155_5555_5555;
    tick();
    CS_WE = 1'b0;
    check("collide_csa", 64'(CSA),      64'd9);
    check("collide_mir", 64'(MIR_WORD), 64'h155_5555_5555);

    // Address wrap from 2047 to 0
    RESET_InHigh = 1'b1;
    w0 = mkword(3'd6, 11'd2047);
    wr(11'd0, w0);
    wr(11'd2047, mkword(3'd0, 11'd77));
    RESET_InHigh = 1'b0;
    tick(); tick();
    check("wrap_pre_csa", 64'(CSA), 64'd2047);
    tick();
    check("wrap_csa", 64'(CSA),      64'd0);
    check("wrap_mir", 64'(MIR_WORD), 64'(w0));

    // Randomized traffic against the reference
    for (int i = 0; i < 400; i++) begin
      set_flags(5'($urandom()));
      DECODE_ADDRESS = 11'($urandom_range(2047));
      STALL_InHigh   = ($urandom_range(4) == 0);
      RESET_InHigh   = ($urandom_range(39) == 0);
      CS_WE          = ($urandom_range(2) == 0);
      CS_WADDR       = ($urandom_range(1) == 0) ? model_next() : 11'($urandom_range(2047));
      CS_WDATA       = rnd_word();
      tick();
      cmp_state("rand");
    end
    CS_WE = 1'b0; RESET_InHigh = 1'b0; STALL_InHigh = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
